// File: rtl/count_column_key_ctrl.sv
// Key front-end for the count column: synchronise, debounce, arbitrate and emit clean step pulses.
// Define COUNT_COLUMN_AUTO_REPEAT_EN to compile in hold-to-repeat (HOLD/REPEAT stepping).
module count_column_key_ctrl #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned PULSE_W       = 2,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned REPEAT_CYCLES = 8
) (
    input  logic clk,
    input  logic key0_rst,
    input  logic key1_inc_up,
    input  logic key2_inc_down,
    output logic inc_up_n,
    output logic inc_down_n,
    output logic busy,
    output logic repeating
);

    localparam int unsigned MaxAB = (DEB_CYCLES > PULSE_W) ? DEB_CYCLES : PULSE_W;
    localparam int unsigned MaxCD = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned MaxP  = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned CW    = $clog2(MaxP) + 1;

    localparam logic [CW-1:0] DebLast   = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] PulseLast = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] CntOne    = CW'(1);
`ifdef COUNT_COLUMN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] PulseW    = CW'(PULSE_W);
    localparam logic [CW-1:0] HoldLast  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RepLast   = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle, StDebounce, StFirst, StHold, StRepeat, StLock, StRelease
    } state_e;

    state_e          state_q, state_d;
    logic            dir_up_q, dir_up_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic            out_up_q, out_up_d, out_dn_q, out_dn_d;
    logic            su, sd, key_hi, other_hi, pulse;

    assign su       = sync2_q[1];
    assign sd       = sync2_q[0];
    assign key_hi   = dir_up_q ? su : sd;
    assign other_hi = dir_up_q ? sd : su;

    always_ff @(posedge clk or negedge key0_rst) begin
        if (!key0_rst) begin
            state_q  <= StIdle;
            dir_up_q <= 1'b0;
            cnt_q    <= '0;
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            out_up_q <= 1'b1;
            out_dn_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            out_up_q <= out_up_d;
            out_dn_q <= out_dn_d;
        end
    end

    always_comb begin
        sync1_d  = {key1_inc_up, key2_inc_down};
        sync2_d  = sync1_q;
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!su && !sd) begin
                    state_d = StLock;
                end else if (!su || !sd) begin
                    dir_up_d = !su;
                    state_d  = StDebounce;
                end
            end
            StDebounce: begin
                if (key_hi) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!other_hi) begin
                    state_d = StLock;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StFirst;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            // cnt keeps running from the first pulse start so HOLD measures from there
            StFirst: begin
                if (cnt_q == PulseLast) begin
                    if (key_hi) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                    end else begin
                        state_d = StHold;
                        cnt_d   = cnt_q + CntOne;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
`ifdef COUNT_COLUMN_AUTO_REPEAT_EN
            StHold: begin
                if (key_hi) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRepeat;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            // Release only once the current pulse has run its full width
            StRepeat: begin
                if (key_hi && cnt_q >= PulseLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else if (cnt_q == RepLast) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
`else
            StHold: begin
                if (key_hi) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
`endif
            StLock: begin
                if (su && sd) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (!(su && sd)) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pulse = (state_q == StFirst);
`ifdef COUNT_COLUMN_AUTO_REPEAT_EN
        pulse = pulse || ((state_q == StRepeat) && (cnt_q < PulseW));
        repeating = (state_q == StRepeat);
`else
        repeating = 1'b0;
`endif
        out_up_d = !(pulse && dir_up_q);
        out_dn_d = !(pulse && !dir_up_q);
        busy     = (state_q != StIdle);
    end

    assign inc_up_n   = out_up_q;
    assign inc_down_n = out_dn_q;

endmodule

// File: tb/tb_count_column_key_ctrl.sv
// Scoreboard bench for count_column_key_ctrl: expected pulse starts are queued at stimulus time.
module tb_count_column_key_ctrl;

    localparam int PW = 2;

    logic clk = 1'b0;
    logic key0_rst = 1'b0;
    logic key1_inc_up = 1'b1;
    logic key2_inc_down = 1'b1;
    logic inc_up_n, inc_down_n, busy, repeating;

    count_column_key_ctrl dut (
        .clk          (clk),
        .key0_rst     (key0_rst),
        .key1_inc_up  (key1_inc_up),
        .key2_inc_down(key2_inc_down),
        .inc_up_n     (inc_up_n),
        .inc_down_n   (inc_down_n),
        .busy         (busy),
        .repeating    (repeating)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit up;
        int start;
    } exp_t;
    exp_t exp_q[$];

`ifdef COUNT_COLUMN_AUTO_REPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    // Pulse monitor: a pulse starts at the cycle of its first low sample.
    initial begin
        int run[2];
        int start[2];
        bit ovl;
        logic lvl;
        exp_t e;
        run[0] = 0; run[1] = 0; ovl = 0;
        forever begin
            @(negedge clk);
            if (!key0_rst) begin
                run[0] = 0; run[1] = 0; ovl = 0;
            end else begin
                if (inc_up_n === 1'b0 && inc_down_n === 1'b0) ovl = 1;
                for (int d = 0; d < 2; d++) begin
                    lvl = (d == 1) ? inc_up_n : inc_down_n;
                    if (lvl === 1'b0) begin
                        if (run[d] == 0) start[d] = cyc;
                        run[d]++;
                    end else if (run[d] > 0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL pulse_unexpected: got up=%0d start=%0d width=%0d, required none",
                                     d, start[d], run[d]);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.up !== (d == 1) || e.start !== start[d] || run[d] !== PW || ovl) begin
                                failures++;
                                $display("FAIL pulse_shape: got up=%0d start=%0d width=%0d overlap=%0d, required up=%0d start=%0d width=%0d overlap=0",
                                         d, start[d], run[d], ovl, e.up, e.start, PW);
                            end
                        end
                        run[d] = 0;
                        ovl = 0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({inc_up_n, inc_down_n, busy, repeating} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 1100", {inc_up_n, inc_down_n, busy, repeating});
        end
        key0_rst = 1'b1;
        tick(3);
        checks++;
        if ({inc_up_n, inc_down_n, busy, repeating} !== 4'b1100) begin
            failures++;
            $display("FAIL post_reset_idle: got %b required 1100", {inc_up_n, inc_down_n, busy, repeating});
        end
    endtask

    task automatic test_single_press(input bit up);
        int n0;
        n0 = cyc + 1;
        if (up) key1_inc_up = 1'b0; else key2_inc_down = 1'b0;
        exp_q.push_back('{up: up, start: n0 + 7});
        tick(6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got %b required 1", busy);
        end
        key1_inc_up = 1'b1;
        key2_inc_down = 1'b1;
        tick(20);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got pending=%0d busy=%b required pending=0 busy=0",
                     exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        logic pat[5];
        pat[0] = 0; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 1;
        for (int i = 0; i < 5; i++) begin
            key2_inc_down = pat[i];
            tick(1);
            if (i == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL bounce_busy_rise: got %b required 1", busy);
                end
            end
        end
        key2_inc_down = 1'b1;
        tick(15);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bounce_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_hold_repeat();
        int n0;
        n0 = cyc + 1;
        key1_inc_up = 1'b0;
        exp_q.push_back('{up: 1'b1, start: n0 + 7});
        if (AutoRep) begin
            exp_q.push_back('{up: 1'b1, start: n0 + 23});
            exp_q.push_back('{up: 1'b1, start: n0 + 31});
            exp_q.push_back('{up: 1'b1, start: n0 + 39});
        end
        tick(30);
        checks++;
        if (repeating !== AutoRep) begin
            failures++;
            $display("FAIL hold_repeating: got %b required %b", repeating, AutoRep);
        end
        tick(10);
        key1_inc_up = 1'b1;
        tick(25);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || repeating !== 1'b0) begin
            failures++;
            $display("FAIL hold_done: got pending=%0d busy=%b repeating=%b required 0 0 0",
                     exp_q.size(), busy, repeating);
            exp_q.delete();
        end
    endtask

    task automatic test_simultaneous();
        key1_inc_up = 1'b0;
        key2_inc_down = 1'b0;
        tick(20);
        key1_inc_up = 1'b1;
        key2_inc_down = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL simul_lock_busy: got %b required 1", busy);
        end
        tick(6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL simul_release_busy: got %b required 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL simul_idle: got %b required 0", busy);
        end
        tick(5);
    endtask

    task automatic test_cross_press();
        int n0;
        n0 = cyc + 1;
        key1_inc_up = 1'b0;
        exp_q.push_back('{up: 1'b1, start: n0 + 7});
        if (AutoRep) exp_q.push_back('{up: 1'b1, start: n0 + 23});
        tick(10);
        key2_inc_down = 1'b0;
        tick(10);
        key2_inc_down = 1'b1;
        tick(6);
        key1_inc_up = 1'b1;
        tick(20);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cross_done: got pending=%0d busy=%b required pending=0 busy=0",
                     exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n0;
        key1_inc_up = 1'b0;
        tick(8);
        checks++;
        if (inc_up_n !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pulse_low: got %b required 0", inc_up_n);
        end
        #2;
        key0_rst = 1'b0;
        #1;
        checks++;
        if (inc_up_n !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: got inc_up_n=%b busy=%b required 1 0", inc_up_n, busy);
        end
        key1_inc_up = 1'b1;
        tick(3);
        key0_rst = 1'b1;
        tick(3);
        n0 = cyc + 1;
        key1_inc_up = 1'b0;
        exp_q.push_back('{up: 1'b1, start: n0 + 7});
        tick(6);
        key1_inc_up = 1'b1;
        tick(20);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_fresh_press: got pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_press(1'b1);
        test_single_press(1'b0);
        test_bounce();
        test_hold_repeat();
        test_simultaneous();
        test_cross_press();
        test_reset_mid_pulse();
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
